// File: rtl/lookahead_pkg.sv
// ---------------------------------------------------------------------------
// lookahead_pkg
// Shared definitions for the carry-lookahead adder sweep controller: the
// sequencer state encoding and the vector / sum widths.
// No ports (package).
// ---------------------------------------------------------------------------
package lookahead_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_CHECK  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam int VEC_W   = 5;
   localparam int NUM_VEC = 32;
   localparam int SUM_W   = 3;

   localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

endpackage

// File: rtl/dwell_timer.sv
// ---------------------------------------------------------------------------
// dwell_timer
// Free-standing settle counter. Clears to zero, counts up while enabled and
// flags the terminal count DWELL-1.
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   clr_i  in   synchronous clear (wins over enable)
//   en_i   in   count enable
//   tc_o   out  high while the count equals DWELL-1
// ---------------------------------------------------------------------------
module dwell_timer #(
   parameter int DWELL = 4,
   parameter int CNT_W = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear has priority, otherwise increment when enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == CNT_W'(DWELL - 1));

endmodule

// File: rtl/lookahead_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// lookahead_sweep_ctrl
// On-chip sequencer that walks all 32 {a, b, c_in} combinations through the
// 2-bit carry-lookahead adder, lets each vector settle for DWELL cycles,
// samples the returned sum and counts mismatches against a local reference.
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   begins a sweep from IDLE or DONE (ignored while busy)
//   pause    in   freezes sequencing while high
//   sum_in   in   {c_out, s[1:0]} from the adder datapath
//   op_a     out  operand a
//   op_b     out  operand b
//   op_cin   out  carry-in
//   index    out  current vector number = {op_a, op_b, op_cin}
//   busy     out  high in LOAD / SETTLE / CHECK
//   done     out  high from sweep completion until the next start
//   err_cnt  out  mismatch count of the current or last sweep (0..32)
//   fail     out  err_cnt != 0 (combinational)
// ---------------------------------------------------------------------------
module lookahead_sweep_ctrl
   import lookahead_pkg::*;
#(
   parameter int DWELL = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             pause,
   input  logic [SUM_W-1:0] sum_in,
   output logic [1:0]       op_a,
   output logic [1:0]       op_b,
   output logic             op_cin,
   output logic [VEC_W-1:0] index,
   output logic             busy,
   output logic             done,
   output logic [5:0]       err_cnt,
   output logic             fail
);

   state_t           state_q;
   state_t           state_d;
   logic [VEC_W-1:0] index_q;
   logic [VEC_W-1:0] index_d;
   logic [5:0]       err_q;
   logic [5:0]       err_d;
   logic             busy_q;
   logic             busy_d;
   logic             done_q;
   logic             done_d;

   logic             timer_clr_s;
   logic             timer_en_s;
   logic             timer_tc_s;
   logic [SUM_W-1:0] ref_sum_s;

   // The timer restarts on every LOAD and only advances in unpaused SETTLE.
   assign timer_clr_s = (state_q == ST_LOAD);
   assign timer_en_s  = (state_q == ST_SETTLE) && !pause;

   dwell_timer #(
      .DWELL (DWELL),
      .CNT_W (CNT_W)
   ) u_dwell_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (timer_clr_s),
      .en_i  (timer_en_s),
      .tc_o  (timer_tc_s)
   );

   // Expected adder result for the vector currently being driven.
   assign ref_sum_s = {1'b0, index_q[4:3]} + {1'b0, index_q[2:1]} + {2'b00, index_q[0]};

   // Next-state, vector index and mismatch counter.
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            // start is honoured even with pause high; the sweep then waits in LOAD.
            if (start) begin
               state_d = ST_LOAD;
               index_d = '0;
               err_d   = 6'd0;
            end else begin
               state_d = state_q;
            end
         end
         ST_LOAD: begin
            if (!pause) begin
               state_d = ST_SETTLE;
            end else begin
               state_d = state_q;
            end
         end
         ST_SETTLE: begin
            if (!pause && timer_tc_s) begin
               state_d = ST_CHECK;
            end else begin
               state_d = state_q;
            end
         end
         ST_CHECK: begin
            // A paused CHECK stays put, so the sample is taken exactly once.
            if (!pause) begin
               if (sum_in != ref_sum_s) begin
                  err_d = err_q + 6'd1;
               end else begin
                  err_d = err_q;
               end
               if (index_q == LAST_VEC) begin
                  state_d = ST_DONE;
               end else begin
                  index_d = index_q + 5'd1;
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            index_d = '0;
            err_d   = 6'd0;
         end
      endcase
      busy_d = (state_d == ST_LOAD) || (state_d == ST_SETTLE) || (state_d == ST_CHECK);
      done_d = (state_d == ST_DONE);
   end

   // Controller registers; the status flags are registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         index_q <= '0;
         err_q   <= 6'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Operands are wired straight from the index register, so they always match it.
   assign op_a    = index_q[4:3];
   assign op_b    = index_q[2:1];
   assign op_cin  = index_q[0];
   assign index   = index_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err_cnt = err_q;
   assign fail    = (err_q != 6'd0);

endmodule

// File: tb/tb_lookahead_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lookahead_sweep_ctrl
// Scoreboard bench: the stimulus process pushes the expected index steps and
// the expected end-of-sweep record; a monitor process pops and compares them
// whenever the DUT steps its index or raises done.
// ---------------------------------------------------------------------------
module tb_lookahead_sweep_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       pause;
   logic       fault;
   logic [2:0] sum_in;
   logic [1:0] op_a;
   logic [1:0] op_b;
   logic       op_cin;
   logic [4:0] index;
   logic       busy;
   logic       done;
   logic [5:0] err_cnt;
   logic       fail;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cyc = 0;

   typedef struct {
      int cycles;
      int err;
      int fail_v;
      int a;
      int b;
      int cin;
   } done_exp_t;

   int        exp_idx_q[$];
   done_exp_t exp_done_q[$];

   logic [2:0] true_sum;

   lookahead_sweep_ctrl #(
      .DWELL (4),
      .CNT_W (16)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .pause   (pause),
      .sum_in  (sum_in),
      .op_a    (op_a),
      .op_b    (op_b),
      .op_cin  (op_cin),
      .index   (index),
      .busy    (busy),
      .done    (done),
      .err_cnt (err_cnt),
      .fail    (fail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Adder model; fault forces sum bit0 stuck-at-0.
   assign true_sum = {1'b0, op_a} + {1'b0, op_b} + {2'b00, op_cin};
   assign sum_in   = fault ? {true_sum[2:1], 1'b0} : true_sum;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: index steps while busy, and the rising edge of done.
   initial begin : monitor
      logic [4:0] prev_idx;
      logic       prev_done;
      int         e;
      done_exp_t  d;
      prev_idx  = 5'd0;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (busy && (index != prev_idx)) begin
            if (exp_idx_q.size() == 0) begin
               check("unexpected_index_step", int'(index), -1);
            end else begin
               e = exp_idx_q.pop_front();
               check("index_step", int'(index), e);
            end
         end
         if (done && !prev_done) begin
            if (exp_done_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               d = exp_done_q.pop_front();
               check("done_cycle", cyc - start_cyc, d.cycles);
               check("done_err_cnt", int'(err_cnt), d.err);
               check("done_fail", int'(fail), d.fail_v);
               check("done_op_a", int'(op_a), d.a);
               check("done_op_b", int'(op_b), d.b);
               check("done_op_cin", int'(op_cin), d.cin);
               check("done_busy", int'(busy), 0);
            end
         end
         prev_idx  = index;
         prev_done = done;
      end
   end

   task automatic push_sweep(input int first, input int cycles, input int err, input int fl);
      done_exp_t d;
      for (int i = first; i < 32; i++) exp_idx_q.push_back(i);
      d.cycles = cycles;
      d.err    = err;
      d.fail_v = fl;
      d.a      = 3;
      d.b      = 3;
      d.cin    = 1;
      exp_done_q.push_back(d);
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1;
      start     = 1'b1;
      start_cyc = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!done && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({name, "_done_reached"}, int'(done), 1);
      @(negedge clk);
      #1;
   endtask

   task automatic wait_index(input int v);
      int n;
      n = 0;
      while ((int'(index) != v) && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("reached_index", int'(index), v);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_index"}, int'(index), 0);
      check({tag, "_op_a"}, int'(op_a), 0);
      check({tag, "_op_b"}, int'(op_b), 0);
      check({tag, "_op_cin"}, int'(op_cin), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
      check({tag, "_err_cnt"}, int'(err_cnt), 0);
      check({tag, "_fail"}, int'(fail), 0);
   endtask

   // Directed stimulus.
   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      pause = 1'b0;
      fault = 1'b0;
      #1;
      check_all_zero("reset");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle_busy", int'(busy), 0);

      // Sweep A: correct adder from IDLE.
      push_sweep(1, 193, 0, 0);
      pulse_start();
      check("sweep_a_busy", int'(busy), 1);
      wait_done("sweep_a");

      // Sweep B: sum bit0 stuck-at-0, every odd sum mismatches.
      fault = 1'b1;
      push_sweep(0, 193, 16, 1);
      pulse_start();
      wait_done("sweep_b");
      fault = 1'b0;

      // Sweep C: restart from DONE clears the result on the next cycle.
      push_sweep(0, 193, 0, 0);
      pulse_start();
      check("restart_done_cleared", int'(done), 0);
      check("restart_err_cleared", int'(err_cnt), 0);
      check("restart_fail_cleared", int'(fail), 0);
      check("restart_busy", int'(busy), 1);
      wait_done("sweep_c");

      // Sweep D: pause for 20 cycles in SETTLE of vector 10.
      push_sweep(0, 213, 0, 0);
      pulse_start();
      wait_index(10);
      @(posedge clk);
      #1;
      pause = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         check("pause_index", int'(index), 10);
         check("pause_ops", int'({op_a, op_b, op_cin}), 10);
         check("pause_busy", int'(busy), 1);
      end
      pause = 1'b0;
      wait_done("sweep_d");

      // Sweep E: start re-pulsed while busy is ignored.
      push_sweep(0, 193, 0, 0);
      pulse_start();
      wait_index(5);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("restart_ignored_busy", int'(busy), 1);
      wait_done("sweep_e");

      // Sweep F: asynchronous reset at vector 17, then a clean sweep.
      push_sweep(0, 193, 0, 0);
      pulse_start();
      wait_index(17);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      exp_idx_q.delete();
      exp_done_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      push_sweep(1, 193, 0, 0);
      pulse_start();
      wait_done("sweep_g");

      check("index_queue_drained", exp_idx_q.size(), 0);
      check("done_queue_drained", exp_done_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lookahead_sweep_ctrl.md
Name: lookahead_sweep_ctrl

Overview:
- Clocked sequencer that exhaustively exercises the 2-bit carry-lookahead adder datapath in hardware.
- Drives all 32 operand combinations {a, b, c_in}, holds each for a programmable dwell, and samples the adder's 3-bit sum.
- Checks each sample against an internally computed reference and reports a mismatch count.
- Sits between board switches/buttons (start, pause) and the adder + seven-segment path; replaces the bench-only loop with on-chip sequencing.

Parameters:
- DWELL, 4, settle cycles per vector before sampling; legal range 1..65535.
- CNT_W, 16, width of the dwell counter; must satisfy 2^CNT_W > DWELL.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; one-cycle pulse begins a sweep
- pause  in  1  level; high freezes sequencing
- sum_in  in  3  {c_out, s[1:0]} returned from the adder datapath
- op_a  out  2  operand a to datapath
- op_b  out  2  operand b to datapath
- op_cin  out  1  carry-in to datapath
- index  out  5  current vector number, equal to {op_a, op_b, op_cin}
- busy  out  1  high while a sweep is in progress
- done  out  1  high from sweep completion until the next start
- err_cnt  out  6  mismatches in the current or last sweep, range 0..32
- fail  out  1  high when err_cnt != 0

Behaviour:
- Reset, asynchronous, any state: state=IDLE; op_a=op_b=0, op_cin=0, index=0; busy=0, done=0, err_cnt=0, fail=0; dwell counter=0.
- States and transitions:
  - IDLE: on start=1, go to LOAD; err_cnt clears to 0; index=0.
  - LOAD: drive operands from index; dwell counter=0; go to SETTLE.
  - SETTLE: counter increments each cycle; when counter==DWELL-1, go to CHECK.
  - CHECK: compare sum_in with op_a+op_b+op_cin, all zero-extended to 3 bits. On mismatch, err_cnt+1.
    - index==31: go to DONE.
    - Otherwise: index+1, go to LOAD.
  - DONE: done=1, busy=0, operands hold the last vector (3,3,1). On start=1, clear err_cnt, done=0, go to LOAD with index=0.
- Vector order: c_in toggles fastest, then b, then a; index increments 0..31 with no wrap inside a sweep.
- busy=1 in LOAD, SETTLE and CHECK.
- Timing per vector: DWELL+2 cycles. Full sweep from the start pulse to done=1: 32*(DWELL+2)+1 cycles.
  - Default DWELL=4: done rises 193 cycles after the start edge.
- start while busy=1: ignored; no restart, no clear.
- pause=1: state, index, counter and err_cnt all hold. Outputs stay stable.
  - pause asserted in the same cycle as a CHECK: the check is deferred to the first unpaused cycle and counted once only.
  - start and pause both high in IDLE: the sweep begins but immediately holds in LOAD.
- err_cnt cannot overflow: 32 is the maximum and fits in 6 bits; no saturation logic.
- fail is combinational from err_cnt.
- All other outputs are registered.
- Reset mid-sweep: immediate return to the reset values; no partial result is retained.

Decomposition:
- Shared package lookahead_pkg holds:
  - state encoding: IDLE=0, LOAD=1, SETTLE=2, CHECK=3, DONE=4, 3 bits;
  - VEC_W=5;
  - NUM_VEC=32;
  - SUM_W=3.
- One natural sub-module: dwell_timer (CNT_W counter with clear, enable and terminal-count output at DWELL-1). It is reused later for display multiplexing.
- Reference-sum computation stays inline in the controller.

Test Plan:
- Correct adder (bench models sum_in=a+b+cin combinationally), start pulse:
  - index steps 0..31 in order;
  - done=1 at cycle 193;
  - err_cnt=0, fail=0;
  - final op_a=3, op_b=3, op_cin=1.
- Fault injection: bench forces sum_in bit0 stuck-at-0 → err_cnt=16 and fail=1 at done.
- pause held high for 20 cycles at index=10 during SETTLE:
  - index and operands stay frozen;
  - done arrives at cycle 213;
  - err_cnt is unaffected.
- start re-pulsed at index=5 while busy → ignored; sweep completes normally at cycle 193.
- rst_n low at index=17:
  - all outputs return to 0 asynchronously, before the next clock edge;
  - a new start afterwards completes a clean sweep.
- After done with err_cnt=16, pulse start → err_cnt=0 and done=0 on the next cycle; second sweep with a correct adder ends with err_cnt=0.
